// File: rtl/inst_prefetch_queue_if.sv
// Signal bundle between the prefetch queue, instruction memory and decode.
// The master side is the prefetch queue itself.
interface inst_prefetch_queue_if;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [63:0] out_pc;

  modport master (
    input  stall, redirect, redirect_pc, mem_rvalid, mem_rdata,
    output mem_req, mem_addr, out_valid, out_inst, out_pc
  );

  modport slave (
    output stall, redirect, redirect_pc, mem_rvalid, mem_rdata,
    input  mem_req, mem_addr, out_valid, out_inst, out_pc
  );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Sequential instruction prefetch queue feeding IF/ID: one outstanding memory
// request, a small {pc, inst} FIFO, stall hold and branch-redirect flush.
module inst_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  reset,
  inst_prefetch_queue_if.master bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t             state_r;
  logic [63:0]        fetch_pc_r;
  logic [63:0]        req_pc_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [63:0]        pc_mem_r   [DEPTH];
  logic [31:0]        inst_mem_r [DEPTH];

  logic               req_s;
  logic               push_s;
  logic               pop_s;
  logic               has_data_s;

  // Request, push and pop qualifiers; redirect suppresses all three.
  always_comb begin
    req_s      = 1'b0;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    has_data_s = (count_r != {CNT_W{1'b0}});
    // reset gating keeps mem_req low while the block is held in reset
    if (reset && (state_r == ST_IDLE) && (count_r < CNT_W'(DEPTH)) && !bus.redirect) begin
      req_s = 1'b1;
    end else begin
      req_s = 1'b0;
    end
    if ((state_r == ST_WAIT) && bus.mem_rvalid && !bus.redirect) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if (has_data_s && !bus.stall && !bus.redirect) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  assign bus.mem_req   = req_s;
  assign bus.mem_addr  = fetch_pc_r;
  assign bus.out_valid = has_data_s;
  assign bus.out_inst  = has_data_s ? inst_mem_r[rd_ptr_r] : NOP_INST;
  assign bus.out_pc    = has_data_s ? pc_mem_r[rd_ptr_r]   : 64'h0;

  // Fetch FSM: tracks the single outstanding request and the fetch address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      fetch_pc_r <= RESET_PC;
      req_pc_r   <= 64'h0;
    end else if (bus.redirect) begin
      fetch_pc_r <= bus.redirect_pc;
      case (state_r)
        ST_IDLE: state_r <= ST_IDLE;
        ST_WAIT: state_r <= bus.mem_rvalid ? ST_IDLE : ST_DROP;
        ST_DROP: state_r <= bus.mem_rvalid ? ST_IDLE : ST_DROP;
        default: state_r <= ST_IDLE;
      endcase
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_s) begin
            req_pc_r   <= fetch_pc_r;
            fetch_pc_r <= fetch_pc_r + 64'd4;
            state_r    <= ST_WAIT;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_WAIT: state_r <= bus.mem_rvalid ? ST_IDLE : ST_WAIT;
        // a response owed to a flushed path is swallowed here
        ST_DROP: state_r <= bus.mem_rvalid ? ST_IDLE : ST_DROP;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (bus.redirect) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage: the returned word is written with the PC it was fetched from.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_r[i]   <= 64'h0;
        inst_mem_r[i] <= 32'h0;
      end
    end else if (push_s) begin
      pc_mem_r[wr_ptr_r]   <= req_pc_r;
      inst_mem_r[wr_ptr_r] <= bus.mem_rdata;
    end
  end

endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
Fetch-side prefetch buffer that sits directly upstream of the IF/ID pipeline register. It issues sequential instruction-word requests to instruction memory over a request/response handshake and queues the returned words with their PCs in a small FIFO. It presents the oldest entry to decode, stalls on hazard back-pressure, and flushes on a taken-branch redirect from ID.

Parameters:
DEPTH, 4, number of FIFO entries (power of two, >=2)
RESET_PC, 64'h0, first fetch address after reset
NOP_INST, 32'h00000013, instruction presented when the queue is empty (addi x0,x0,0)

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-low reset
stall  input  1  decode back-pressure (PCnotWrite/IFIDnotWrite); high = hold head entry
redirect  input  1  taken branch resolved in ID (PCSrc)
redirect_pc  input  64  branch target (PCbranch_id)
mem_req  output  1  request valid toward instruction memory
mem_addr  output  64  word address of request
mem_rvalid  input  1  response valid, one cycle
mem_rdata  input  32  response instruction word
out_valid  output  1  head entry valid
out_inst  output  32  head instruction, NOP_INST when empty
out_pc  output  64  head PC, 0 when empty

Behaviour:
- Reset (reset low, async): fetch_pc=RESET_PC, req_pc=0, count=0, rd/wr pointers=0, state=IDLE; mem_req=0, out_valid=0, out_inst=NOP_INST, out_pc=0.
- Storage: DEPTH entries of {pc[63:0], inst[31:0]}; pointers log2(DEPTH) bits, wrap modulo DEPTH; count 0..DEPTH.
- FSM states: IDLE (no request outstanding), WAIT (one request outstanding, response to be kept), DROP (one request outstanding, response to be discarded).
- At most one outstanding request.
- mem_req is combinational: (state==IDLE) && (count<DEPTH) && !redirect. mem_addr=fetch_pc at all times.
- A request is accepted in the cycle mem_req is high: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (64-bit wrap), IDLE->WAIT.
- WAIT with mem_rvalid: push {req_pc, mem_rdata}, go to IDLE. The next request is issued no earlier than the following cycle.
- Memory latency is any value >=1 cycle. mem_rvalid in IDLE is ignored.
- Output: out_valid=(count!=0). out_inst/out_pc come combinationally from the head entry. A pushed entry becomes visible the cycle after mem_rvalid; there is no bypass.
- Pop occurs when out_valid && !stall && !redirect; rd_ptr advances.
- Push and pop in the same cycle leave count unchanged. Push into a full queue is impossible by construction, because a request is only issued when count<DEPTH.
- redirect has top priority, applied in the cycle it is high:
  - queue flushed: count=0, rd_ptr=wr_ptr=0
  - fetch_pc<=redirect_pc
  - no pop
  - any response arriving in that cycle is discarded
  - state: IDLE->IDLE, WAIT->DROP (unless mem_rvalid in the same cycle, then ->IDLE), DROP stays DROP (->IDLE if mem_rvalid in the same cycle)
- DROP with mem_rvalid (and no redirect): discard the word, go to IDLE; no push.
- Repeated redirects: the last redirect_pc wins.
- stall and redirect together: redirect wins and the flush occurs.
- Reset asserted mid-request: all state clears immediately. A response after reset release while in IDLE is ignored.
- redirect_pc is not alignment-checked; the low 2 bits pass through.

Test Plan:
- Reset release, memory latency 1, stall=0: requests to 0x0, 0x4, 0x8 on alternating cycles. out_pc sequence 0x0, 0x4, 0x8 with matching inst. out_valid first high 2 cycles after the first request.
- stall held high for 10 cycles, latency 1: queue fills to DEPTH=4 (PCs 0x0-0xC), then mem_req stays 0. On stall release, heads pop 0x0..0xC one per cycle and fetching resumes at 0x10.
- Redirect to 0x100 while queue holds 3 entries and state IDLE: next cycle out_valid=0 and mem_addr=0x100. The next out_pc is 0x100.
- Redirect to 0x200 while in WAIT (latency 3), response returns 2 cycles later: that word is never output. The next request is 0x200 after DROP->IDLE, and out_pc=0x200.
- Redirect and mem_rvalid in the same cycle while in WAIT: word discarded, state IDLE. The next cycle mem_req=1 with mem_addr=redirect_pc.
- Reset asserted while in WAIT with 2 queued entries: out_valid=0, out_inst=0x00000013, and mem_req=0 immediately. After release, a stray mem_rvalid is ignored and the first request is to RESET_PC.
